// File: rtl/comparador_pkg.sv
// Shared definitions for the comparator-flag filter: FSM states, one-hot
// result codes and the legal range of the stability window.
package comparador_pkg;

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    CONTANDO = 2'd1,
    FIJO     = 2'd2,
    FALLA    = 2'd3
  } estado_t;

  localparam logic [2:0] MAYOR   = 3'b100;
  localparam logic [2:0] IGUAL   = 3'b010;
  localparam logic [2:0] MENOR   = 3'b001;
  localparam logic [2:0] NINGUNO = 3'b000;

  localparam int ESTABLE_MIN = 2;
  localparam int ESTABLE_MAX = 15;

  // A flag vector is meaningful only when exactly one comparator flag is set.
  function automatic logic es_valido(input logic [2:0] v);
    return (v == MAYOR) || (v == IGUAL) || (v == MENOR);
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// Event counter that sticks at its maximum instead of wrapping.
// clr has priority over inc so a clear on the same edge always yields zero.
module contador_saturado #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] suma_sat(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= suma_sat(cnt);
    end
  end

endmodule

// File: rtl/filtro_comparador.sv
// Debounces the A>B / A=B / A<B comparator flags: a result is accepted only
// after ESTABLE_CICLOS identical one-hot samples, and accepted results are counted.
module filtro_comparador
  import comparador_pkg::*;
#(
  parameter int ESTABLE_CICLOS = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             F1,
  input  logic             F2,
  input  logic             F3,
  input  logic             en,
  input  logic             clear,
  output logic             G,
  output logic             E,
  output logic             L,
  output logic             cambio,
  output logic             error,
  output logic [CNT_W-1:0] cnt_mayor,
  output logic [CNT_W-1:0] cnt_igual,
  output logic [CNT_W-1:0] cnt_menor
);

  if (ESTABLE_CICLOS < ESTABLE_MIN || ESTABLE_CICLOS > ESTABLE_MAX) begin : g_param_invalido
    $error("filtro_comparador: ESTABLE_CICLOS out of range 2..15");
  end

  localparam logic [3:0] OBJETIVO = 4'(ESTABLE_CICLOS);

  estado_t    estado, estado_sig;
  logic [2:0] v_p0;
  logic [2:0] cand, cand_sig;
  logic [2:0] res, res_sig;
  logic [3:0] cuenta, cuenta_sig;
  logic       acepta;

  // Stage p0: flag register, keeps sampling even while the filter is frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      v_p0 <= NINGUNO;
    end else begin
      v_p0 <= {F1, F2, F3};
    end
  end

  always_comb begin
    estado_sig = estado;
    cand_sig   = cand;
    cuenta_sig = cuenta;
    res_sig    = res;
    acepta     = 1'b0;
    if (en) begin
      case (estado)
        INICIO, FALLA: begin
          if (es_valido(v_p0)) begin
            estado_sig = CONTANDO;
            cand_sig   = v_p0;
            cuenta_sig = 4'd1;
          end else begin
            estado_sig = FALLA;
          end
        end
        CONTANDO: begin
          if (!es_valido(v_p0)) begin
            estado_sig = FALLA;
          end else if (v_p0 == cand) begin
            cuenta_sig = cuenta + 4'd1;
            if (cuenta + 4'd1 == OBJETIVO) begin
              estado_sig = FIJO;
              res_sig    = cand;
              acepta     = 1'b1;
            end
          end else begin
            cand_sig   = v_p0;
            cuenta_sig = 4'd1;
          end
        end
        FIJO: begin
          if (!es_valido(v_p0)) begin
            estado_sig = FALLA;
          end else if (v_p0 != res) begin
            estado_sig = CONTANDO;
            cand_sig   = v_p0;
            cuenta_sig = 4'd1;
          end
        end
      endcase
    end
  end

  // Stage p1: filter state and accepted result
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= INICIO;
      cand   <= NINGUNO;
      cuenta <= '0;
      res    <= NINGUNO;
      cambio <= 1'b0;
    end else begin
      estado <= estado_sig;
      cand   <= cand_sig;
      cuenta <= cuenta_sig;
      res    <= res_sig;
      cambio <= acepta && (cand != res);
    end
  end

  assign {G, E, L} = res;
  assign error     = (estado == FALLA);

  contador_saturado #(.CNT_W(CNT_W)) u_cnt_mayor (
    .clk(clk), .rst(rst), .inc(acepta && (cand == MAYOR)), .clr(clear), .cnt(cnt_mayor)
  );
  contador_saturado #(.CNT_W(CNT_W)) u_cnt_igual (
    .clk(clk), .rst(rst), .inc(acepta && (cand == IGUAL)), .clr(clear), .cnt(cnt_igual)
  );
  contador_saturado #(.CNT_W(CNT_W)) u_cnt_menor (
    .clk(clk), .rst(rst), .inc(acepta && (cand == MENOR)), .clr(clear), .cnt(cnt_menor)
  );

endmodule
